// File: rtl/fir_xifu_ctrl.sv
// fir_xifu_ctrl: control/scheduling unit of the FIR XIFU pipeline.
//   Tracks the commit/kill status of every offloaded instruction ID, sequences
//   EX-stage xfirlw/xfirsw memory transactions against the core's mem handshake,
//   bounds outstanding transactions and produces the EX/WB pipeline-advance ready.
// Ports:
//   clk_i, rst_ni (async, active-low), clear_i (synchronous flush)
//   issue_*   : issue handshake in, issue_ready_o = slot of issue_id_i is free
//   commit_*  : commit/kill strobe in, commit_o/kill_o per-ID status vectors out
//   ex_*      : EX-stage instruction descriptor
//   mem_ready_i, mem_result_valid_i : core mem handshake
//   wb_done_i, wb_id_i : WB retirement
//   ready_o   : pipeline advance enable (combinational from mem_ready_i)
//   outstanding_o : accepted transactions awaiting a result
//   perf_stall_o, perf_memreq_o : performance counters
// Optional feature: define FIR_XIFU_CTRL_PERF_EN to build the perf counters;
//   otherwise both perf outputs are tied to zero and no counter flops exist.
module fir_xifu_ctrl #(
  parameter int unsigned  NB_ID           = 16,
  parameter int unsigned  MAX_OUTSTANDING = 2,
  localparam int unsigned IDW             = $clog2(NB_ID),
  localparam int unsigned OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             issue_valid_i,
  input  logic             issue_accept_i,
  input  logic [IDW-1:0]   issue_id_i,
  output logic             issue_ready_o,
  input  logic             commit_valid_i,
  input  logic [IDW-1:0]   commit_id_i,
  input  logic             commit_kill_i,
  output logic [NB_ID-1:0] commit_o,
  output logic [NB_ID-1:0] kill_o,
  input  logic             ex_valid_i,
  input  logic             ex_mem_i,
  input  logic             ex_store_i,
  input  logic [IDW-1:0]   ex_id_i,
  input  logic             mem_ready_i,
  input  logic             mem_result_valid_i,
  input  logic             wb_done_i,
  input  logic [IDW-1:0]   wb_id_i,
  output logic             ready_o,
  output logic [OW-1:0]    outstanding_o,
  output logic [31:0]      perf_stall_o,
  output logic [31:0]      perf_memreq_o
);

  typedef enum logic [1:0] {SLOT_FREE, SLOT_ISSUED, SLOT_COMMITTED, SLOT_KILLED} slot_e;
  typedef enum logic {MEM_IDLE, MEM_REQ} mem_e;

  slot_e            slot_q [NB_ID];
  slot_e            slot_d [NB_ID];
  mem_e             mem_q, mem_d;
  logic [OW-1:0]    out_q, out_d;
  logic [NB_ID-1:0] commit_q, commit_d, kill_q, kill_d;

  logic ex_killed_c, ex_memop_c, store_ok_c, start_c, mem_req_c, accept_c, ready_c;

  // Request/accept decode. A qualifying EX op presents its request in the same
  // cycle it arrives, so a single-cycle accept costs no bubble; MEM_REQ holds a
  // request that was presented but not yet accepted.
  always_comb begin
    ex_killed_c = ex_valid_i && (slot_q[ex_id_i] == SLOT_KILLED);
    ex_memop_c  = ex_valid_i && ex_mem_i && !ex_killed_c;
    store_ok_c  = !ex_store_i || (slot_q[ex_id_i] == SLOT_COMMITTED);
    start_c     = (mem_q == MEM_IDLE) && ex_memop_c && store_ok_c &&
                  (out_q < OW'(MAX_OUTSTANDING));
    mem_req_c   = (mem_q == MEM_REQ) || start_c;
    accept_c    = mem_req_c && mem_ready_i && !clear_i;
    // A pending request blocks the advance until accepted, even if its slot was
    // killed meanwhile, so the held request stays tied to its instruction.
    ready_c     = clear_i || accept_c || ((mem_q == MEM_IDLE) && !ex_memop_c);
  end

  assign ready_o       = ready_c;
  assign issue_ready_o = (slot_q[issue_id_i] == SLOT_FREE);
  assign commit_o      = commit_q;
  assign kill_o        = kill_q;
  assign outstanding_o = out_q;

  // Next-state for the mem FSM, outstanding counter and per-ID slot FSMs.
  always_comb begin
    mem_d = mem_q;
    out_d = out_q;
    for (int unsigned i = 0; i < NB_ID; i++) slot_d[i] = slot_q[i];

    if (clear_i) begin
      mem_d = MEM_IDLE;
      out_d = '0;
      for (int unsigned i = 0; i < NB_ID; i++) slot_d[i] = SLOT_FREE;
    end else begin
      if (accept_c)       mem_d = MEM_IDLE;
      else if (mem_req_c) mem_d = MEM_REQ;

      // Same-cycle accept and result cancel; a result at zero is dropped.
      if (accept_c && !mem_result_valid_i)                      out_d = out_q + OW'(1);
      else if (!accept_c && mem_result_valid_i && out_q != '0)  out_d = out_q - OW'(1);

      for (int unsigned i = 0; i < NB_ID; i++) begin
        if (issue_valid_i && issue_accept_i && issue_id_i == IDW'(i)) begin
          slot_d[i] = SLOT_ISSUED;
        end else if (commit_valid_i && commit_id_i == IDW'(i) && slot_q[i] == SLOT_ISSUED) begin
          slot_d[i] = commit_kill_i ? SLOT_KILLED : SLOT_COMMITTED;
        end else if ((slot_q[i] == SLOT_COMMITTED || slot_q[i] == SLOT_KILLED) &&
                     ((wb_done_i && wb_id_i == IDW'(i)) ||
                      (ex_killed_c && ready_c && ex_id_i == IDW'(i)))) begin
          slot_d[i] = SLOT_FREE;
        end
      end
    end

    for (int unsigned i = 0; i < NB_ID; i++) begin
      commit_d[i] = (slot_d[i] == SLOT_COMMITTED);
      kill_d[i]   = (slot_d[i] == SLOT_KILLED);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NB_ID; i++) slot_q[i] <= SLOT_FREE;
      mem_q    <= MEM_IDLE;
      out_q    <= '0;
      commit_q <= '0;
      kill_q   <= '0;
    end else begin
      slot_q   <= slot_d;
      mem_q    <= mem_d;
      out_q    <= out_d;
      commit_q <= commit_d;
      kill_q   <= kill_d;
    end
  end

`ifdef FIR_XIFU_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, memreq_cnt_q, memreq_cnt_d;

  // Free-running wrap-around counters, flushed by clear_i.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    memreq_cnt_d = memreq_cnt_q;
    if (clear_i) begin
      stall_cnt_d  = '0;
      memreq_cnt_d = '0;
    end else begin
      if (ex_valid_i && !ready_c) stall_cnt_d  = stall_cnt_q + 32'd1;
      if (accept_c)               memreq_cnt_d = memreq_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q  <= '0;
      memreq_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      memreq_cnt_q <= memreq_cnt_d;
    end
  end

  assign perf_stall_o  = stall_cnt_q;
  assign perf_memreq_o = memreq_cnt_q;
`else
  assign perf_stall_o  = '0;
  assign perf_memreq_o = '0;
`endif

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// tb_fir_xifu_ctrl: directed scenarios followed by a randomized phase, every
// cycle compared against a behavioural model of the ID slots, pending request,
// outstanding count and perf counters.
module tb_fir_xifu_ctrl;
  localparam int NB   = 16;
  localparam int MAXO = 2;
  localparam int S_FREE = 0, S_ISSUED = 1, S_COMMITTED = 2, S_KILLED = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni, clear_i;
  logic        issue_valid_i, issue_accept_i, issue_ready_o;
  logic [3:0]  issue_id_i, commit_id_i, ex_id_i, wb_id_i;
  logic        commit_valid_i, commit_kill_i;
  logic [15:0] commit_o, kill_o;
  logic        ex_valid_i, ex_mem_i, ex_store_i;
  logic        mem_ready_i, mem_result_valid_i, wb_done_i, ready_o;
  logic [1:0]  outstanding_o;
  logic [31:0] perf_stall_o, perf_memreq_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int       m_slot [NB];
  bit       m_pend;
  int       m_out;
  bit [31:0] m_stall, m_memreq;
  bit       m_last_rdy;

  always #5 clk_i = ~clk_i;

  fir_xifu_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_accept_i(issue_accept_i),
    .issue_id_i(issue_id_i), .issue_ready_o(issue_ready_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i), .commit_o(commit_o), .kill_o(kill_o),
    .ex_valid_i(ex_valid_i), .ex_mem_i(ex_mem_i), .ex_store_i(ex_store_i),
    .ex_id_i(ex_id_i), .mem_ready_i(mem_ready_i),
    .mem_result_valid_i(mem_result_valid_i), .wb_done_i(wb_done_i),
    .wb_id_i(wb_id_i), .ready_o(ready_o), .outstanding_o(outstanding_o),
    .perf_stall_o(perf_stall_o), .perf_memreq_o(perf_memreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    clear_i = 0; issue_valid_i = 0; issue_accept_i = 0; issue_id_i = 0;
    commit_valid_i = 0; commit_id_i = 0; commit_kill_i = 0;
    ex_valid_i = 0; ex_mem_i = 0; ex_store_i = 0; ex_id_i = 0;
    mem_ready_i = 0; mem_result_valid_i = 0; wb_done_i = 0; wb_id_i = 0;
  endtask

  function automatic void mdl_reset();
    for (int i = 0; i < NB; i++) m_slot[i] = S_FREE;
    m_pend = 0; m_out = 0; m_stall = 0; m_memreq = 0;
  endfunction

  // Expected advance/accept for the current inputs, phrased as stall reasons.
  function automatic void mdl_eval(output bit rdy, output bit acc, output bit start);
    bit killed, memop, store_uncommitted, full;
    killed            = ex_valid_i && m_slot[ex_id_i] == S_KILLED;
    memop             = ex_valid_i && ex_mem_i && !killed;
    store_uncommitted = ex_store_i && m_slot[ex_id_i] != S_COMMITTED;
    full              = m_out >= MAXO;
    start = !m_pend && memop && !store_uncommitted && !full;
    acc   = !clear_i && mem_ready_i && (m_pend || start);
    if (clear_i)     rdy = 1;
    else if (m_pend) rdy = mem_ready_i;
    else if (memop)  rdy = acc;
    else             rdy = 1;
  endfunction

  task automatic mdl_check();
    bit rdy, acc, start;
    logic [15:0] ec, ek;
    mdl_eval(rdy, acc, start);
    m_last_rdy = rdy;
    for (int i = 0; i < NB; i++) begin
      ec[i] = (m_slot[i] == S_COMMITTED);
      ek[i] = (m_slot[i] == S_KILLED);
    end
    chk("ready_o", ready_o, rdy);
    chk("issue_ready_o", issue_ready_o, m_slot[issue_id_i] == S_FREE);
    chk("commit_o", commit_o, ec);
    chk("kill_o", kill_o, ek);
    chk("outstanding_o", outstanding_o, m_out);
`ifdef FIR_XIFU_CTRL_PERF_EN
    chk("perf_stall_o", perf_stall_o, m_stall);
    chk("perf_memreq_o", perf_memreq_o, m_memreq);
`else
    chk("perf_stall_o", perf_stall_o, 0);
    chk("perf_memreq_o", perf_memreq_o, 0);
`endif
  endtask

  task automatic mdl_update();
    bit rdy, acc, start;
    int nxt [NB];
    if (!rst_ni || clear_i) begin mdl_reset(); return; end
    mdl_eval(rdy, acc, start);
    if (ex_valid_i && !rdy) m_stall++;
    if (acc) m_memreq++;
    m_pend = acc ? 1'b0 : (m_pend || start);
    m_out  = m_out + (acc ? 1 : 0) - ((mem_result_valid_i && (m_out > 0 || acc)) ? 1 : 0);
    nxt = m_slot;
    for (int i = 0; i < NB; i++) begin
      if (issue_valid_i && issue_accept_i && issue_id_i == i)
        nxt[i] = S_ISSUED;
      else if (commit_valid_i && commit_id_i == i && m_slot[i] == S_ISSUED)
        nxt[i] = commit_kill_i ? S_KILLED : S_COMMITTED;
      else if ((m_slot[i] == S_COMMITTED || m_slot[i] == S_KILLED) &&
               ((wb_done_i && wb_id_i == i) ||
                (ex_valid_i && ex_id_i == i && m_slot[i] == S_KILLED && rdy)))
        nxt[i] = S_FREE;
    end
    m_slot = nxt;
  endtask

  // One clock: model check mid-cycle, then edge, model update, drive point.
  task automatic tick();
    #2;
    mdl_check();
    @(posedge clk_i);
    mdl_update();
    #1;
  endtask

  task automatic issue(input int id);
    idle(); issue_valid_i = 1; issue_accept_i = 1; issue_id_i = 4'(id); tick();
  endtask

  task automatic ex_op(input int id, input bit store, input bit mr);
    idle(); ex_valid_i = 1; ex_mem_i = 1; ex_store_i = store; ex_id_i = 4'(id);
    mem_ready_i = mr;
  endtask

  initial begin
    bit [31:0] stall_base;
    idle(); rst_ni = 0; mdl_reset();
    #2;
    chk("rst_ready", ready_o, 1);
    chk("rst_issue_ready", issue_ready_o, 1);
    chk("rst_commit", commit_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    @(posedge clk_i); #1; rst_ni = 1;

    // 1: issue/commit id3, load accepted in one cycle
    issue(3);
    idle(); commit_valid_i = 1; commit_id_i = 3; tick();
    ex_op(3, 0, 1); #1;
    chk("t1_ready", ready_o, 1);
    chk("t1_commit3", commit_o[3], 1);
    tick();
    idle(); #1; chk("t1_outstanding", outstanding_o, 1);
    mem_result_valid_i = 1; tick();
    idle(); wb_done_i = 1; wb_id_i = 3; tick();
    idle(); issue_id_i = 3; #1; chk("t1_freed", issue_ready_o, 1); tick();

    // 2: store waits for its commit
    issue(5);
    ex_op(5, 1, 1); #1; chk("t2_stall_uncommitted", ready_o, 0); tick();
    commit_valid_i = 1; commit_id_i = 5; #1; chk("t2_stall_commit_cycle", ready_o, 0); tick();
    commit_valid_i = 0; #1;
    chk("t2_ready_after_commit", ready_o, 1);
    chk("t2_commit5", commit_o[5], 1);
    tick();
    idle(); #1; chk("t2_outstanding", outstanding_o, 1);
    mem_result_valid_i = 1; tick();
    idle(); wb_done_i = 1; wb_id_i = 5; tick();

    // 3: killed store passes without a request
    issue(7);
    idle(); commit_valid_i = 1; commit_id_i = 7; commit_kill_i = 1; tick();
    ex_op(7, 1, 1); #1;
    chk("t3_kill7", kill_o[7], 1);
    chk("t3_ready", ready_o, 1);
    tick();
    idle(); issue_id_i = 7; #1;
    chk("t3_slot7_free", issue_ready_o, 1);
    chk("t3_no_request", outstanding_o, 0);
    tick();

    // 4: third back-to-back load blocked by the outstanding limit
    issue(1); issue(2); issue(4);
    ex_op(1, 0, 1); #1; chk("t4_load1", ready_o, 1); tick();
    ex_op(2, 0, 1); #1; chk("t4_load2", ready_o, 1); tick();
    ex_op(4, 0, 1); #1;
    chk("t4_full_stall", ready_o, 0);
    chk("t4_outstanding2", outstanding_o, 2);
    tick(); tick();
    mem_result_valid_i = 1; #1; chk("t4_stall_result_cycle", ready_o, 0); tick();
    mem_result_valid_i = 0; #1;
    chk("t4_proceeds", ready_o, 1);
    chk("t4_outstanding1", outstanding_o, 1);
    tick();
    idle(); mem_result_valid_i = 1; tick(); tick();

    // 5: mem_ready low for four cycles while requesting
    issue(9);
    stall_base = m_stall;
    ex_op(9, 0, 0);
    for (int k = 0; k < 4; k++) begin #1; chk("t5_stall", ready_o, 0); tick(); end
    mem_ready_i = 1; #1;
    chk("t5_accept", ready_o, 1);
`ifdef FIR_XIFU_CTRL_PERF_EN
    chk("t5_perf_stall", perf_stall_o, stall_base + 32'd4);
`else
    chk("t5_perf_stall", perf_stall_o, 0);
`endif
    tick();
    idle(); mem_result_valid_i = 1; tick();

    // 6: clear_i while a request is pending, then async reset with two outstanding
    issue(10);
    ex_op(10, 0, 1); tick();
    ex_op(10, 0, 0); tick();
    clear_i = 1; #1; chk("t6_clear_ready", ready_o, 1); tick();
    idle(); issue_id_i = 10; #1;
    chk("t6_clear_out", outstanding_o, 0);
    chk("t6_clear_issue_ready", issue_ready_o, 1);
    chk("t6_clear_perf", perf_memreq_o, 0);
    tick();
    ex_op(10, 0, 1); tick(); tick();
    ex_op(10, 0, 0); #1; chk("t6_out2", outstanding_o, 2);
    idle(); rst_ni = 0; #1;
    mdl_reset();
    chk("t6_rst_out", outstanding_o, 0);
    chk("t6_rst_ready", ready_o, 1);
    chk("t6_rst_commit", commit_o, 0);
    tick();
    rst_ni = 1; tick();

    // Randomized phase; EX is held while the model says the pipe is stalled.
    m_last_rdy = 1;
    for (int c = 0; c < 3000; c++) begin
      bit hold_ex;
      logic [3:0] hid;
      bit hv, hm, hs;
      hold_ex = !m_last_rdy;
      hv = ex_valid_i; hm = ex_mem_i; hs = ex_store_i; hid = ex_id_i;
      idle();
      clear_i        = ($urandom_range(99) < 2);
      issue_valid_i  = ($urandom_range(99) < 40);
      issue_accept_i = ($urandom_range(99) < 80);
      issue_id_i     = 4'($urandom_range(15));
      commit_valid_i = ($urandom_range(99) < 40);
      commit_kill_i  = ($urandom_range(99) < 25);
      mem_ready_i    = ($urandom_range(99) < 60);
      mem_result_valid_i = ($urandom_range(99) < 35);
      wb_done_i      = ($urandom_range(99) < 30);
      wb_id_i        = 4'($urandom_range(15));
      if (hold_ex) begin
        ex_valid_i = hv; ex_mem_i = hm; ex_store_i = hs; ex_id_i = hid;
      end else begin
        ex_valid_i = ($urandom_range(99) < 70);
        ex_mem_i   = ($urandom_range(99) < 60);
        ex_store_i = ($urandom_range(99) < 50);
        ex_id_i    = 4'($urandom_range(15));
      end
      commit_id_i = ($urandom_range(1) == 1) ? ex_id_i : 4'($urandom_range(15));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
